// File: rtl/uart_rx_port.sv
// uart_rx_port: memory-mapped UART receiver with a small byte FIFO.
//   DATA   at BASE_ADDR   : FIFO head byte (8'h00 when empty), read has no side effect.
//   STATUS at BASE_ADDR+1 : {BUSY, PERR, FERR, OVR, count[3:0]}.
//   Write STATUS bit0 pops one byte, bit1 clears the sticky error flags.
// Optional feature: define UART_RX_PARITY_EN to receive an even-parity bit
// between the data bits and the stop bit (8E1 instead of 8N1).
module uart_rx_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF10,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH_LOG2   = 3
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        write_en,
  output logic [7:0]  data_out,
  output logic        sel,
  input  logic        uart_rx
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0]         STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0]         BIT_CNT   = 16'(CLKS_PER_BIT);
  localparam logic [15:0]         HALF_CNT  = 16'(CLKS_PER_BIT / 2);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // Line synchronizer and falling-edge detection
  logic       rx_meta, rx_sync, rx_prev;
  logic [1:0] sync_fill;
  logic       fall_edge;

  // Receiver state
  logic [2:0]  state;
  logic [15:0] bit_timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic        timer_done;
  logic        par_bad;

  // Frame results for the current cycle
  logic push, set_ferr, set_perr;

  // FIFO and flags
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovr, ferr, perr;
  logic                  stat_wr, pop, clr, full, do_push, drop;
  logic [7:0]            head_byte, status_byte;
  logic                  unused_data;

  assign unused_data = ^data_in[7:2];

  // Two-flop synchronizer; rx_prev only becomes high from a genuinely
  // sampled high line, so a line held low across reset release never
  // looks like a start-bit edge.
  always_ff @(posedge clk_in or negedge reset_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!reset_in) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= sync_fill[1] & rx_sync;
    end
  end

  assign fall_edge  = rx_prev & ~rx_sync;
  assign timer_done = (bit_timer == 16'd1);

  // Receiver FSM: start qualification, data shifting, optional parity, stop
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      bit_timer <= 16'd0;
      bit_idx   <= 3'd0;
      shift_q   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fall_edge) begin
            state     <= START;
            bit_timer <= HALF_CNT;
          end
        end
        START: begin
          if (timer_done) begin
            if (!rx_sync) begin
              state     <= DATA;
              bit_timer <= BIT_CNT;
              bit_idx   <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_bad   <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        DATA: begin
          if (timer_done) begin
            shift_q   <= {rx_sync, shift_q[7:1]};
            bit_timer <= BIT_CNT;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer_done) begin
            par_bad   <= (^shift_q) ^ rx_sync;
            state     <= STOP;
            bit_timer <= BIT_CNT;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
`endif
        STOP: begin
          if (timer_done) state <= IDLE;
          else            bit_timer <= bit_timer - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign set_perr = (state == PARITY) && timer_done && ((^shift_q) != rx_sync);
`else
  assign par_bad  = 1'b0;
  assign set_perr = 1'b0;
`endif
  assign push     = (state == STOP) && timer_done && rx_sync && !par_bad;
  assign set_ferr = (state == STOP) && timer_done && !rx_sync;

  // CPU side decode
  assign stat_wr = write_en && (addr == STAT_ADDR);
  assign pop     = stat_wr && data_in[0] && (count != '0);
  assign clr     = stat_wr && data_in[1];
  assign full    = (count == FULL_CNT);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // FIFO storage
  always_ff @(posedge clk_in) begin
    // NOTE: the storage array has no reset; emptiness is tracked by count,
    // and unreset RAM maps onto plain memory cells.
    if (do_push) mem[wr_ptr] <= shift_q;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= drop     | (ovr  & ~clr);
      ferr <= set_ferr | (ferr & ~clr);
      perr <= set_perr | (perr & ~clr);
    end
  end

  assign sel         = (addr == BASE_ADDR) || (addr == STAT_ADDR);
  assign head_byte   = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign status_byte = {(state != IDLE), perr, ferr, ovr, 4'(count)};

  // Read mux
  always_comb begin
    // NOTE: default first so every path assigns data_out and no latch is inferred.
    data_out = 8'h00;
    if (addr == BASE_ADDR)      data_out = head_byte;
    else if (addr == STAT_ADDR) data_out = status_byte;
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: scoreboard bench for uart_rx_port (default 8N1 build).
// Expected register values come from a queue-based model of the FIFO and
// flags; a monitor process compares them against the bus on the falling edge.
`timescale 1ns/1ps
module tb_uart_rx_port;

  localparam int          CPB  = 16;
  localparam logic [15:0] BASE = 16'hFF10;
  localparam logic [15:0] STAT = 16'hFF11;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        write_en;
  logic [7:0]  data_out;
  logic        sel;
  logic        uart_rx;

  uart_rx_port #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (3)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .sel      (sel),
    .uart_rx  (uart_rx)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected {sel, data_out} plus a name for each pending read
  logic [8:0] exp_q[$];
  string      tag_q[$];

  // Reference model
  logic [7:0] model_q[$];
  bit         m_ovr, m_ferr;
  int         busy_drop_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {1'b0, 1'b0, m_ferr, m_ovr, 4'(model_q.size())};
  endfunction

  function automatic logic [7:0] exp_data();
    return (model_q.size() != 0) ? model_q[0] : 8'h00;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)               m_ferr = 1'b1;
    else if (model_q.size() == 8) m_ovr = 1'b1;
    else                        model_q.push_back(b);
  endtask

  task automatic model_pop();
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Monitor: compares each pending expectation against the bus
  always @(negedge clk_in) begin
    logic [8:0] e;
    string      t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {23'b0, sel, data_out}, {23'b0, e});
    end
  end

  task automatic expect_reg(input logic [15:0] a, input logic [8:0] e, input string t);
    @(posedge clk_in); #1;
    addr = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk_in); #1;
    if (exp_q.size() != 0) check({t, "_monitor_stall"}, exp_q.size(), 0);
  endtask

  task automatic expect_status(input string t);
    expect_reg(STAT, {1'b1, exp_status()}, t);
  endtask

  task automatic expect_data(input string t);
    expect_reg(BASE, {1'b1, exp_data()}, t);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] v);
    @(posedge clk_in); #1;
    addr = a; data_in = v; write_en = 1'b1;
    @(posedge clk_in); #1;
    write_en = 1'b0; data_in = 8'h00;
  endtask

  task automatic hold_line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Drives one frame; watches BUSY during the stop bit and optionally
  // issues a pop write landing on a chosen stop-bit clock edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int pop_edge);
    int drop;
    @(posedge clk_in); #1;
    addr = STAT;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
    uart_rx = stop_bit;
    drop = 0;
    for (int i = 1; i <= CPB; i++) begin
      if (i == pop_edge) begin
        data_in = 8'h01; write_en = 1'b1;
      end
      @(posedge clk_in); #1;
      write_en = 1'b0; data_in = 8'h00;
      if (drop == 0 && data_out[7] == 1'b0) drop = i;
    end
    check("busy_ends_in_stop_bit", drop != 0, 1);
    if (drop != 0) busy_drop_edge = drop;
    hold_line(1'b1, 4);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         good, saw_busy;
    int         act;

    reset_in = 1'b0; uart_rx = 1'b1; addr = 16'h0000;
    data_in = 8'h00; write_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 reset_in = 1'b1;
    repeat (4) @(posedge clk_in);

    // Reset state and decode
    expect_status("reset_status");
    expect_data("reset_data");
    expect_reg(16'hFF12, 9'h000, "unmapped_ff12");
    expect_reg(16'hFF0F, 9'h000, "unmapped_ff0f");

    // Single byte, DATA-register write ignored, pop
    send_frame(8'hA5, 1'b1, 0); model_frame(8'hA5, 1'b1);
    expect_status("a5_status");
    expect_data("a5_data");
    wr_reg(BASE, 8'h03);
    expect_status("data_write_ignored_status");
    expect_data("data_write_ignored_data");
    wr_reg(STAT, 8'h01); model_pop();
    expect_status("a5_popped_status");

    // Start-bit glitch while idle
    @(posedge clk_in); #1;
    addr = STAT; saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      uart_rx = (i < 4) ? 1'b0 : 1'b1;
      @(posedge clk_in); #1;
      saw_busy |= data_out[7];
    end
    check("glitch_busy_seen", saw_busy, 1);
    expect_status("glitch_status");
    expect_data("glitch_data");

    // Framing error, clear, pop while empty
    send_frame(8'h3C, 1'b0, 0); model_frame(8'h3C, 1'b0);
    expect_status("ferr_status");
    expect_data("ferr_data");
    wr_reg(STAT, 8'h02); m_ferr = 1'b0;
    expect_status("ferr_cleared");
    wr_reg(STAT, 8'h01); model_pop();
    expect_status("pop_empty_status");

    // Fill, overflow, drain in order
    for (int i = 0; i < 8; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, 0); model_frame(b, 1'b1);
    end
    expect_status("full_status");
    send_frame(8'h08, 1'b1, 0); model_frame(8'h08, 1'b1);
    expect_status("ovr_status");
    expect_data("ovr_head");
    for (int i = 0; i < 8; i++) begin
      expect_data("drain_after_ovr");
      wr_reg(STAT, 8'h01); model_pop();
    end
    expect_status("drained_ovr_sticky");
    wr_reg(STAT, 8'h02); m_ovr = 1'b0;
    expect_status("ovr_cleared");

    // Pop on the same edge as a push into a full FIFO
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      send_frame(b, 1'b1, 0); model_frame(b, 1'b1);
    end
    send_frame(8'h18, 1'b1, busy_drop_edge);
    model_pop(); model_frame(8'h18, 1'b1);
    expect_status("push_pop_full_status");
    for (int i = 0; i < 8; i++) begin
      expect_data("drain_after_push_pop");
      wr_reg(STAT, 8'h01); model_pop();
    end
    expect_status("push_pop_drained");

    // Randomized frames with random pops and clears
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 99) >= 15);
      send_frame(b, good, 0); model_frame(b, good);
      expect_status("rand_status");
      expect_data("rand_data");
      act = $urandom_range(0, 9);
      if (act < 5) begin
        wr_reg(STAT, 8'h01); model_pop();
      end else if (act == 5) begin
        wr_reg(STAT, 8'h02); m_ovr = 1'b0; m_ferr = 1'b0;
      end else if (act == 6) begin
        wr_reg(STAT, 8'h03); model_pop(); m_ovr = 1'b0; m_ferr = 1'b0;
      end
    end
    expect_status("rand_final_status");

    // Reset in the middle of the data bits of 0x0F
    send_frame(8'h5A, 1'b1, 0); model_frame(8'h5A, 1'b1);
    @(posedge clk_in); #1;
    addr = STAT;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 5; i++) hold_line((i < 4) ? 1'b1 : 1'b0, CPB);
    hold_line(1'b0, CPB / 2);
    reset_in = 1'b0;
    #1;
    check("reset_now_status", {sel, data_out}, 9'h100);
    addr = BASE;
    #1;
    check("reset_now_data", {sel, data_out}, 9'h100);
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b1;
    addr = STAT; saw_busy = 1'b0;
    for (int i = 0; i < CPB / 2 + 2 * CPB; i++) begin
      uart_rx = 1'b0;
      @(posedge clk_in); #1;
      saw_busy |= data_out[7];
    end
    for (int i = 0; i < CPB + 40; i++) begin
      uart_rx = 1'b1;
      @(posedge clk_in); #1;
      saw_busy |= data_out[7];
    end
    check("post_reset_no_busy", saw_busy, 0);
    expect_status("post_reset_status");
    expect_data("post_reset_data");

    // Receiver still works after reset
    send_frame(8'hC3, 1'b1, 0); model_frame(8'hC3, 1'b1);
    expect_status("after_reset_frame_status");
    expect_data("after_reset_frame_data");

    repeat (4) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
